remap_pixel_packer: RTL
=======================

# remap_pixel_packer

Downstream of the bilinear interpolation stage in the remap_v2 pipeline. Takes the interpolator's 17-bit stream (bit 16 = gray/out-of-bounds flag, bits 15:0 = RGB565) and substitutes a fill colour for flagged pixels. Packs four pixels per 64-bit word, tags line and frame boundaries, and buffers the words in a small FIFO. The output is a valid/ready stream for the frame-buffer write master. The interpolator has no backpressure, so the FIFO absorbs write-master stalls, and any loss is flagged rather than stalling upstream.

## Interface
Parameters:
- LINE_PIXELS, 1440: output pixels per line; must be a multiple of 4.
- FRAME_LINES, 1440: lines per frame.
- FIFO_DEPTH, 16: words; power of 2, ≥ 4.
- GRAY_RGB565, 16'h8410: fill colour for flagged pixels.

Ports:
- clk, in, 1: single clock.
- reset_n, in, 1: asynchronous, active-low reset.
- frame_start, in, 1: one-cycle pulse that realigns to the start of a frame.
- pixel_in, in, 17: {gray, R5, G6, B5}.
- pixel_in_valid, in, 1: qualifies pixel_in.
- word_out, out, 64: pixel k of the word at bits [16k+15:16k], k = 0 is leftmost.
- word_out_sop, out, 1: first word of a frame.
- word_out_eol, out, 1: last word of a line.
- word_out_valid, out, 1: FIFO not empty.
- word_out_ready, in, 1: consumer accepts when valid & ready.
- frame_done, out, 1: one-cycle pulse when the last word of a frame is accepted.
- overflow, out, 1: sticky; a word was dropped.
- overflow_clear, in, 1: clears overflow.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: words currently buffered.

## Operation
- Substitution: pixel = gray ? GRAY_RGB565 : pixel_in[15:0]. Applied before packing.
- Lane counter 0..3 advances on each pixel_in_valid. Lane k is registered into the assembly register at [16k+15:16k]. Lanes 0–2 are held until lane 3 arrives.
- On lane 3, the push word is {sop, eol, assembly[47:0] with lane 3 inserted}.
  - sop = (x_word == 0 && y == 0).
  - eol = (x_word == LINE_PIXELS/4−1).
- Position counters:
  - x_word wraps 0..LINE_PIXELS/4−1.
  - y increments at eol and wraps 0..FRAME_LINES−1 after the last line, so the next frame is tagged sop without needing frame_start.
- frame_start clears lane, x_word and y, and discards any partial word.
  - If frame_start and pixel_in_valid occur in the same cycle, the pixel becomes lane 0 of the new frame.
- Push handling:
  - Push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow is set. Counters still advance, so geometry stays aligned.
- overflow:
  - overflow_clear takes effect in the same cycle.
  - If a drop and overflow_clear occur in the same cycle, overflow = 1 (set wins).
- frame_done pulses on the acceptance of a word that has eol = 1 and was pushed with y == FRAME_LINES−1. This tag is stored as a third sideband bit in the FIFO.
- Arithmetic: fifo_level = wr_ptr − rd_ptr, using pointers one bit wider than the address.

## Timing
- Reset values:
  - word_out_valid = 0, frame_done = 0, overflow = 0, fifo_level = 0.
  - word_out, word_out_sop and word_out_eol = 0 (FIFO storage cleared).
  - Lane, x_word and y = 0.
- Reset mid-frame discards all buffered and partial words. The next pixel after release is lane 0 and will be tagged sop.
- Latency: a lane-3 pixel sampled at edge N is written into an empty FIFO at edge N. word_out_valid and word_out are valid after edge N (one cycle from input to output).
- The FIFO is show-ahead. word_out holds stable while valid & !ready.
- fifo_level updates the cycle after a push or pop, and is unchanged on a simultaneous push and pop.
- Sustained throughput: one pixel per cycle in produces one word per four cycles out; the output can accept one word per cycle.

## Structure
- Package remap_pkg:
  - typedef rgb565_t (16 bits).
  - typedef interp_pixel_t as a struct {gray, rgb565_t}.
  - typedef packed_word_t as a struct {last_of_frame, sop, eol, logic [63:0] data}.
  - Constant GRAY_RGB565_DEFAULT.
- Sub-module remap_sync_fifo:
  - Parameterised width (67) and depth.
  - Show-ahead, asynchronous active-low reset.
  - Ports: push, pop, full, empty and level outputs.
- The packer top holds the substitution logic, the lane/x/y counters, the drop/overflow logic and the frame_done logic.

## Test plan
- LINE_PIXELS=8, FRAME_LINES=2, ready=1. Feed 16 pixels, values 0x0001..0x0010.
  - Expect 4 words.
  - Word 0 = 64'h0004_0003_0002_0001 with sop=1, eol=0.
  - Word 1 has eol=1. Word 3 has eol=1.
  - frame_done pulses on the acceptance of word 3.
- Pixel 2 input = 17'h1_FFFF → lane 2 of the word = 16'h8410.
- ready=0 for the full FIFO_DEPTH=4 words plus one more word.
  - Expect overflow=1 and fifo_level=4.
  - The first 4 words are retained intact.
  - After ready=1, the next accepted word still carries the correct eol position.
- Feed 2 pixels, then frame_start together with a pixel.
  - The partial word is discarded.
  - The next word contains the new pixel in lane 0 and has sop=1.
- FIFO full, then push and pop in the same cycle → no drop, fifo_level stays 4, overflow=0.
- reset_n low mid-line with 3 words buffered.
  - Outputs go to 0 immediately (asynchronously).
  - After release, the first complete word has sop=1.

Source files
------------

// File: rtl/remap_pkg.sv
// remap_pkg: shared pixel and packed-word types for the remap_v2 output stage
//   rgb565_t            : 16-bit RGB565 colour
//   interp_pixel_t      : interpolator output {gray/out-of-bounds flag, RGB565}
//   packed_word_t       : FIFO entry {last_of_frame, sop, eol, four packed pixels}
//   GRAY_RGB565_DEFAULT : fill colour substituted for flagged pixels
package remap_pkg;
    typedef logic [15:0] rgb565_t;
    typedef struct packed {
        logic    gray;
        rgb565_t rgb;
    } interp_pixel_t;
    typedef struct packed {
        logic        last_of_frame;
        logic        sop;
        logic        eol;
        logic [63:0] data;
    } packed_word_t;
    localparam rgb565_t GRAY_RGB565_DEFAULT = 16'h8410;
endpackage

// File: rtl/remap_sync_fifo.sv
// remap_sync_fifo: show-ahead synchronous FIFO with pointer-difference level
//   clk, reset_n : clock, asynchronous active-low reset (clears storage too)
//   push, din    : write request and data (taken when not full, or full with a pop)
//   pop, dout    : read request and show-ahead head entry
//   full, empty  : status flags
//   level        : entries currently stored (0..DEPTH)
module remap_sync_fifo #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign level = wr_ptr - rd_ptr;
    assign empty = level == '0;
    // DEPTH is a power of two, so the level MSB alone marks full
    assign full = level[AW];
    assign do_pop = pop && !empty;
    // when full, the slot being written is the one being popped this edge
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/remap_pixel_packer.sv
// remap_pixel_packer: gray-fill substitution, 4-pixel packing, line/frame tagging, output FIFO
//   clk, reset_n        : clock, asynchronous active-low reset
//   frame_start         : realigns lane/x/y to frame start, drops any partial word
//   pixel_in(_valid)    : {gray, RGB565} stream, no backpressure
//   word_out(_sop/_eol) : packed word, pixel k at [16k+15:16k], with frame/line tags
//   word_out_valid/ready: output handshake
//   frame_done          : high while the last word of a frame is accepted
//   overflow(_clear)    : sticky word-dropped flag and its clear
//   fifo_level          : words buffered
module remap_pixel_packer
    import remap_pkg::*;
#(
    parameter int      LINE_PIXELS = 1440,
    parameter int      FRAME_LINES = 1440,
    parameter int      FIFO_DEPTH  = 16,
    parameter rgb565_t GRAY_RGB565 = GRAY_RGB565_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic [16:0]                   pixel_in,
    input  logic                          pixel_in_valid,
    output logic [63:0]                   word_out,
    output logic                          word_out_sop,
    output logic                          word_out_eol,
    output logic                          word_out_valid,
    input  logic                          word_out_ready,
    output logic                          frame_done,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int WPL = LINE_PIXELS / 4;
    localparam int XW = $clog2(WPL + 1);
    localparam int YW = $clog2(FRAME_LINES + 1);
    localparam logic [XW-1:0] LAST_X = XW'(WPL - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(FRAME_LINES - 1);
    interp_pixel_t px;
    rgb565_t pix;
    logic [1:0] lane, lane_e;
    logic [XW-1:0] x_word, x_e;
    logic [YW-1:0] y, y_e;
    logic [47:0] assembly;
    logic last_lane, eol, pop, full, empty;
    packed_word_t push_word, head;
    assign px = pixel_in;
    // *_e are the positions this cycle's pixel lands on; frame_start forces them to origin
    always_comb begin
        pix = px.gray ? GRAY_RGB565 : px.rgb;
        lane_e = frame_start ? 2'd0 : lane;
        x_e = frame_start ? '0 : x_word;
        y_e = frame_start ? '0 : y;
        last_lane = pixel_in_valid && lane_e == 2'd3;
        eol = x_e == LAST_X;
        push_word.last_of_frame = eol && y_e == LAST_Y;
        push_word.sop = x_e == '0 && y_e == '0;
        push_word.eol = eol;
        push_word.data = {pix, assembly};
        pop = word_out_valid && word_out_ready;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            assembly <= '0;
            lane <= '0;
            x_word <= '0;
            y <= '0;
            overflow <= 1'b0;
        end else begin
            if (pixel_in_valid && !last_lane) assembly[16*lane_e +: 16] <= pix;
            lane <= pixel_in_valid ? lane_e + 2'd1 : lane_e;
            // counters advance even when the word is dropped so geometry stays aligned
            x_word <= last_lane ? (eol ? '0 : x_e + 1'b1) : x_e;
            y <= (last_lane && eol) ? (y_e == LAST_Y ? '0 : y_e + 1'b1) : y_e;
            overflow <= (last_lane && full && !pop) || (overflow && !overflow_clear);
        end
    end
    remap_sync_fifo #(
        .WIDTH($bits(packed_word_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(last_lane),
        .din(push_word),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
    assign word_out = head.data;
    assign word_out_sop = head.sop;
    assign word_out_eol = head.eol;
    assign word_out_valid = !empty;
    assign frame_done = pop && head.last_of_frame;
endmodule
